// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : 8N1 UART receiver; bytes are queued in a FIFO when
//               UART_RX_FIFO_EN is defined, otherwise in a holding register.
// Revision    : 1.0  initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int CLK_FRQ   = 0,
    parameter int BAUD_RATE = 0,
    parameter int FIFO_AW   = 11
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               rx_in,
    output logic [7:0]         rx_data,
    output logic               rx_data_ready,
    input  logic               rx_clear,
    input  logic               err_clear,
    output logic               frame_err,
    output logic               overrun,
    output logic [FIFO_AW:0]   rx_count
);
    // Unconfigured rates fall back to a 2-clock bit so the counters stay legal
    localparam int          c_raw      = (BAUD_RATE > 0) ? CLK_FRQ / BAUD_RATE : 2;
    localparam int          c_cycle    = (c_raw < 2) ? 2 : c_raw;
    localparam logic [19:0] c_bit_end  = 20'(c_cycle - 1);
    localparam logic [19:0] c_half_end = 20'(c_cycle / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [19:0] r_cnt, w_cnt_nxt;
    logic [2:0]  r_bit, w_bit_nxt;
    logic [7:0]  r_shift, w_shift_nxt;
    logic        r_sync1, r_sync2, r_line_d;
    logic        r_push, r_frame_err, r_overrun;
    logic        w_fall, w_good_stop, w_bad_stop, w_ovr_set;

    assign w_fall = r_line_d & ~r_sync2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1  <= 1'b1;
            r_sync2  <= 1'b1;
            r_line_d <= 1'b1;
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
            r_push   <= 1'b0;
        end else begin
            r_sync1  <= rx_in;
            r_sync2  <= r_sync1;
            r_line_d <= r_sync2;
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_bit    <= w_bit_nxt;
            r_shift  <= w_shift_nxt;
            r_push   <= w_good_stop;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 20'd1;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_good_stop = 1'b0;
        w_bad_stop  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (w_fall) begin
                    w_state_nxt = S_START;
                    w_bit_nxt   = '0;
                end
            end
            S_START: begin
                if (r_cnt == c_half_end) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = r_sync2 ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (r_cnt == c_bit_end) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = {r_sync2, r_shift[7:1]};
                    w_bit_nxt   = r_bit + 3'd1;
                    if (r_bit == 3'd7) w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                // Return to idle mid stop bit so a back-to-back start is caught
                if (r_cnt == c_bit_end) begin
                    w_cnt_nxt = '0;
                    if (r_sync2) begin
                        w_good_stop = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_bad_stop  = 1'b1;
                        w_state_nxt = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                w_cnt_nxt = '0;
                if (r_sync2) w_state_nxt = S_IDLE;
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

`ifdef UART_RX_FIFO_EN
    localparam int c_depth = 2 ** FIFO_AW;

    logic [7:0]       r_mem [c_depth];
    logic [FIFO_AW:0] r_head, r_tail, w_count;
    logic [7:0]       r_data;
    logic             r_ready, r_clr_d;
    logic             w_full, w_empty, w_pop, w_wr;

    assign w_count   = r_tail - r_head;
    assign w_full    = (w_count == (FIFO_AW + 1)'(c_depth));
    assign w_empty   = (w_count == '0);
    assign w_pop     = rx_clear & ~r_clr_d & ~w_empty;
    assign w_wr      = r_push & (~w_full | w_pop);
    assign w_ovr_set = r_push & w_full & ~w_pop;

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_tail[FIFO_AW-1:0]] <= r_shift;
    end

    // Output register gives first-word fall-through; ready drops for one
    // cycle after a pop while the new head is fetched
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_clr_d <= 1'b0;
            r_data  <= '0;
            r_ready <= 1'b0;
        end else begin
            r_clr_d <= rx_clear;
            if (w_wr)     r_tail <= r_tail + (FIFO_AW + 1)'(1);
            if (w_pop)    r_head <= r_head + (FIFO_AW + 1)'(1);
            if (!w_empty) r_data <= r_mem[r_head[FIFO_AW-1:0]];
            r_ready <= ~w_pop & ~w_empty;
        end
    end

    assign rx_count = w_count;
`else
    logic [7:0] r_data;
    logic       r_ready;

    assign w_ovr_set = r_push & r_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data  <= '0;
            r_ready <= 1'b0;
        end else if (r_push) begin
            r_data  <= r_shift;
            r_ready <= 1'b1;
        end else if (rx_clear) begin
            r_ready <= 1'b0;
        end
    end

    assign rx_count = {{FIFO_AW{1'b0}}, r_ready};
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_bad_stop)     r_frame_err <= 1'b1;
            else if (err_clear) r_frame_err <= 1'b0;
            if (w_ovr_set)      r_overrun   <= 1'b1;
            else if (err_clear) r_overrun   <= 1'b0;
        end
    end

    assign rx_data       = r_data;
    assign rx_data_ready = r_ready;
    assign frame_err     = r_frame_err;
    assign overrun       = r_overrun;
endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_fifo
// Description : Self-checking bench for uart_rx_fifo against a queue model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_uart_rx_fifo;
    localparam int CYC   = 104;
    localparam int AW    = 2;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          rx_in;
    logic [7:0]    rx_data;
    logic          rx_data_ready;
    logic          rx_clear;
    logic          err_clear;
    logic          frame_err;
    logic          overrun;
    logic [AW:0]   rx_count;

    int            n_checks = 0;
    int            n_errors = 0;
    logic [7:0]    q [$];
    logic          m_ferr = 1'b0;
    logic          m_ovr  = 1'b0;

    uart_rx_fifo #(
        .CLK_FRQ  (12_000_000),
        .BAUD_RATE(115200),
        .FIFO_AW  (AW)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .rx_in        (rx_in),
        .rx_data      (rx_data),
        .rx_data_ready(rx_data_ready),
        .rx_clear     (rx_clear),
        .err_clear    (err_clear),
        .frame_err    (frame_err),
        .overrun      (overrun),
        .rx_count     (rx_count)
    );

    always #5 clk = ~clk;

    initial begin
        #(95_000 * 10);
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model: a byte arriving into a full store is lost (FIFO) or replaces
    // the held byte (single register); both raise overrun.
    task automatic model_rx(input logic [7:0] b);
`ifdef UART_RX_FIFO_EN
        if (q.size() < DEPTH) q.push_back(b);
        else m_ovr = 1'b1;
`else
        if (q.size() != 0) begin
            m_ovr = 1'b1;
            q.delete();
        end
        q.push_back(b);
`endif
    endtask

    task automatic model_pop();
`ifdef UART_RX_FIFO_EN
        if (q.size() != 0) void'(q.pop_front());
`else
        q.delete();
`endif
    endtask

    task automatic check_state(input string tag);
        check({tag, ".ready"}, 32'(rx_data_ready), 32'(q.size() != 0));
        check({tag, ".count"}, 32'(rx_count), 32'(q.size()));
        if (q.size() != 0) check({tag, ".data"}, 32'(rx_data), 32'(q[0]));
        check({tag, ".ferr"}, 32'(frame_err), 32'(m_ferr));
        check({tag, ".ovr"}, 32'(overrun), 32'(m_ovr));
    endtask

    // Line bits are sent LSB first, one bit per CYC clocks, for nclk clocks
    task automatic drive(input logic [31:0] bits, input int nclk);
        for (int i = 0; i < nclk; i++) begin
            rx_in = bits[i / CYC];
            @(posedge clk);
            #1;
        end
        rx_in = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        drive({22'h3FFFFF, 1'b1, b, 1'b0}, 10 * CYC);
    endtask

    task automatic send_rx(input logic [7:0] b);
        send_byte(b);
        model_rx(b);
    endtask

    task automatic pop();
        rx_clear = 1'b1;
        wait_clk(1);
        check("pop.gap", 32'(rx_data_ready), 32'd0);
        rx_clear = 1'b0;
        wait_clk(3);
        model_pop();
    endtask

    task automatic clear_err();
        err_clear = 1'b1;
        wait_clk(1);
        err_clear = 1'b0;
        wait_clk(1);
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
    endtask

    initial begin
        logic [7:0] b;
        int         k;
        rx_in     = 1'b1;
        rx_clear  = 1'b0;
        err_clear = 1'b0;
        reset_n   = 1'b0;
        wait_clk(3);
        check_state("reset");
        check("reset.data", 32'(rx_data), 32'd0);
        reset_n = 1'b1;
        wait_clk(3);

        // Single byte
        send_rx(8'h55);
        check_state("t1");
        pop();
        check_state("t1.pop");

        // Short glitch must not start a frame; receiver still works after it
        drive(32'hFFFF_FFFE, 30);
        wait_clk(200);
        check_state("t3");
        send_rx(8'hC6);
        check_state("t3.rx");
        pop();

        // Bad stop bit followed by a 20-bit break
        drive({2'b11, 20'h0, 1'b0, 8'h3C, 1'b0}, 30 * CYC);
        m_ferr = 1'b1;
        wait_clk(5);
        check_state("t4.err");
        send_rx(8'h7E);
        check_state("t4.rx");
        clear_err();
        check_state("t4.clr");
        pop();
        check_state("t4.pop");

`ifdef UART_RX_FIFO_EN
        // Back-to-back frames read out in order
        send_rx(8'h41);
        send_rx(8'h42);
        send_rx(8'h43);
        check_state("t2");
        for (int i = 0; i < 3; i++) begin
            pop();
            check_state("t2.pop");
        end
        // A long rx_clear pulse pops exactly once
        send_rx(8'h11);
        send_rx(8'h22);
        rx_clear = 1'b1;
        wait_clk(1000);
        rx_clear = 1'b0;
        wait_clk(3);
        model_pop();
        check_state("t2.hold");
        pop();

        // Overflow drops the fifth byte
        for (int i = 1; i <= 5; i++) send_rx(8'(i));
        check_state("t5.full");
        clear_err();
        for (int i = 0; i < 4; i++) begin
            pop();
            check_state("t5.pop");
        end
        // Pop landing in the push cycle of a byte arriving into a full FIFO
        for (int i = 0; i < 4; i++) send_rx(8'($urandom_range(0, 255)));
        b = 8'($urandom_range(0, 255));
        fork
            send_byte(b);
            begin
                repeat (991) @(posedge clk);
                #1 rx_clear = 1'b1;
                @(posedge clk);
                #1 rx_clear = 1'b0;
            end
        join
        model_pop();
        model_rx(b);
        wait_clk(3);
        check_state("t5.coinc");
        while (q.size() != 0) begin
            pop();
            check_state("t5.drain");
        end
`endif

        // Random bursts, including overruns
        for (int it = 0; it < 5; it++) begin
            wait_clk($urandom_range(0, 40));
            k = $urandom_range(1, 5);
            for (int j = 0; j < k; j++) send_rx(8'($urandom_range(0, 255)));
            check_state("rnd");
            while (q.size() != 0) begin
                pop();
                check_state("rnd.pop");
            end
            clear_err();
            check_state("rnd.clr");
        end

        // Reset in the middle of bit 4
        send_rx(8'($urandom_range(0, 255)));
        drive({22'h3FFFFF, 1'b1, 8'hC3, 1'b0}, 5 * CYC + CYC / 2);
        reset_n = 1'b0;
        q.delete();
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
        wait_clk(2);
        check_state("t6.rst");
        check("t6.data", 32'(rx_data), 32'd0);
        reset_n = 1'b1;
        wait_clk(2);
        send_rx(8'hA5);
        check_state("t6.rx");
        pop();
        check_state("t6.pop");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
